// File: rtl/ysyx_22050039_lsu_pkg.sv
// ysyx_22050039_lsu_pkg
// Shared definitions for the load/store unit: widths, op-field bit
// positions, access-size encodings, FSM state type and lane-mask helpers.
package ysyx_22050039_lsu_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    // in_op field layout
    localparam int OP_STORE_BIT = 3;
    localparam int OP_UNS_BIT   = 2;

    // Access size encodings (in_op[1:0])
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // All eight byte lanes of the 64-bit data port
    localparam logic [7:0] LANE_MASK_FULL = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Byte-offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_off_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'b000;
            SIZE_H:  return 3'b001;
            SIZE_W:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte enables of an access of the given size starting at lane 0
    function automatic logic [7:0] size_lane_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return LANE_MASK_FULL;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// ysyx_22050039_lsu_align
// Purely combinational lane steering for the LSU.
//   Store side: i_st_off/i_st_size/i_st_wdata -> o_st_wdata (data shifted
//               into its byte lanes), o_st_wmask (byte enables).
//   Load side:  i_ld_off/i_ld_size/i_ld_uns/i_ld_rdata -> o_ld_data
//               (selected bytes right-justified and sign/zero-extended).
// Offset bits below the access size are dropped, so an unaligned offset
// behaves as the access aligned down to its size.
module ysyx_22050039_lsu_align
    import ysyx_22050039_lsu_pkg::*;
(
    input  logic [2:0]      i_st_off,
    input  logic [1:0]      i_st_size,
    input  logic [XLEN-1:0] i_st_wdata,
    output logic [XLEN-1:0] o_st_wdata,
    output logic [7:0]      o_st_wmask,
    input  logic [2:0]      i_ld_off,
    input  logic [1:0]      i_ld_size,
    input  logic            i_ld_uns,
    input  logic [XLEN-1:0] i_ld_rdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [2:0]      w_st_off;
    logic [2:0]      w_ld_off;
    logic [XLEN-1:0] w_ld_shifted;

    assign w_st_off   = i_st_off & ~size_off_mask(i_st_size);
    assign o_st_wdata = i_st_wdata << {w_st_off, 3'b000};
    assign o_st_wmask = size_lane_mask(i_st_size) << w_st_off;

    assign w_ld_off     = i_ld_off & ~size_off_mask(i_ld_size);
    assign w_ld_shifted = i_ld_rdata >> {w_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_ld_shifted;
        case (i_ld_size)
            SIZE_B: o_ld_data = i_ld_uns ? {{56{1'b0}}, w_ld_shifted[7:0]}
                                         : {{56{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            SIZE_H: o_ld_data = i_ld_uns ? {{48{1'b0}}, w_ld_shifted[15:0]}
                                         : {{48{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            SIZE_W: o_ld_data = i_ld_uns ? {{32{1'b0}}, w_ld_shifted[31:0]}
                                         : {{32{w_ld_shifted[31]}}, w_ld_shifted[31:0]};
            default: o_ld_data = w_ld_shifted;   // doubleword ignores unsigned bit
        endcase
    end

endmodule

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu
// Single-outstanding load/store unit between execute and writeback.
//   Upstream:  in_valid/in_ready, in_op, in_addr, in_wdata, in_rd
//   Memory:    mem_req_* (doubleword-aligned request), mem_resp_* (pulse)
//   Writeback: out_valid/out_ready, out_data, out_rd, out_wen, out_misalign
// Clock clk; reset rst is synchronous, active-low.
// Build option YSYX_22050039_LSU_MISALIGN_TRAP_EN: when defined, a
// misaligned op skips the memory port and completes with out_misalign=1.
// All outputs are either registers or decoded from the state register.
module ysyx_22050039_lsu
    import ysyx_22050039_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            out_misalign
);

    lsu_state_t      r_state;
    logic [2:0]      r_off;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [XLEN-1:0] r_mem_req_addr;
    logic            r_mem_req_wen;
    logic [XLEN-1:0] r_mem_req_wdata;
    logic [7:0]      r_mem_req_wmask;
    logic [XLEN-1:0] r_out_data;
    logic [RD_W-1:0] r_out_rd;
    logic            r_out_wen;
    logic            r_out_misalign;

    logic [XLEN-1:0] w_st_wdata;
    logic [7:0]      w_st_wmask;
    logic [XLEN-1:0] w_ld_data;
    logic            w_fault;

`ifdef YSYX_22050039_LSU_MISALIGN_TRAP_EN
    assign w_fault = |(in_addr[2:0] & size_off_mask(in_op[1:0]));
`else
    assign w_fault = 1'b0;
`endif

    // Store steering uses the incoming op so the request is registered at
    // accept; load steering uses latched fields and the raw response.
    ysyx_22050039_lsu_align u_align (
        .i_st_off   (in_addr[2:0]),
        .i_st_size  (in_op[1:0]),
        .i_st_wdata (in_wdata),
        .o_st_wdata (w_st_wdata),
        .o_st_wmask (w_st_wmask),
        .i_ld_off   (r_off),
        .i_ld_size  (r_size),
        .i_ld_uns   (r_uns),
        .i_ld_rdata (mem_resp_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_off           <= 3'b000;
            r_size          <= SIZE_B;
            r_uns           <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wen   <= 1'b0;
            r_mem_req_wdata <= '0;
            r_mem_req_wmask <= 8'h00;
            r_out_data      <= '0;
            r_out_rd        <= '0;
            r_out_wen       <= 1'b0;
            r_out_misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_off           <= in_addr[2:0];
                        r_size          <= in_op[1:0];
                        r_uns           <= in_op[OP_UNS_BIT];
                        r_mem_req_addr  <= {in_addr[XLEN-1:3], 3'b000};
                        r_mem_req_wen   <= in_op[OP_STORE_BIT];
                        r_mem_req_wdata <= in_op[OP_STORE_BIT] ? w_st_wdata : '0;
                        r_mem_req_wmask <= in_op[OP_STORE_BIT] ? w_st_wmask : 8'h00;
                        r_out_data      <= '0;
                        r_out_rd        <= in_rd;
                        if (w_fault) begin
                            r_out_wen      <= 1'b0;
                            r_out_misalign <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            r_out_wen      <= ~in_op[OP_STORE_BIT];
                            r_out_misalign <= 1'b0;
                            r_state        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (!r_mem_req_wen) begin
                            r_out_data <= w_ld_data;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign out_valid     = (r_state == S_DONE);
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wen   = r_mem_req_wen;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_wmask = r_mem_req_wmask;
    assign out_data      = r_out_data;
    assign out_rd        = r_out_rd;
    assign out_wen       = r_out_wen;
    assign out_misalign  = r_out_misalign;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// tb_ysyx_22050039_lsu
// Directed bench for the load/store unit: inputs change on the falling
// edge, outputs are checked on the falling edge, expected values are
// hand-computed constants. Builds with or without
// YSYX_22050039_LSU_MISALIGN_TRAP_EN.
module tb_ysyx_22050039_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22050039_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .out_misalign   (out_misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accepting edge; returns on the next falling edge.
    task automatic accept(input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rd);
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_rd    = rd;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("accept op=%h addr=%h wdata=%h rd=%0d", op, addr, wdata, rd);
    endtask

    task automatic pulse_resp(input logic [63:0] rdata);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_consume", {63'd0, in_ready}, 64'd1);
        chk("out_valid_after_consume", {63'd0, out_valid}, 64'd0);
    endtask

    // Full zero-stall load: accept, request, response, writeback.
    task automatic do_load(input string tag, input logic [3:0] op, input logic [63:0] addr,
                           input logic [4:0] rd, input logic [63:0] rdata,
                           input logic [63:0] exp_addr, input logic [63:0] exp_data);
        accept(op, addr, 64'd0, rd);
        chk({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
        @(negedge clk);
        pulse_resp(rdata);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_out_data"}, out_data, exp_data);
        chk({tag, "_out_wen"}, {63'd0, out_wen}, 64'd1);
        chk({tag, "_out_rd"}, {59'd0, out_rd}, {59'd0, rd});
        $display("load %s addr=%h rdata=%h -> out_data=%h", tag, addr, rdata, out_data);
        consume();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_wen", {63'd0, out_wen}, 64'd0);
        chk("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ld with latency tracking: REQ, WAIT, then DONE
        accept(4'b0011, 64'h8000_0010, 64'd0, 5'd7);
        chk("ld_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("ld_req_addr", mem_req_addr, 64'h8000_0010);
        chk("ld_req_wen", {63'd0, mem_req_wen}, 64'd0);
        chk("ld_req_wmask", {56'd0, mem_req_wmask}, 64'd0);
        chk("ld_in_ready_busy", {63'd0, in_ready}, 64'd0);
        chk("ld_out_valid_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("ld_out_valid_c2", {63'd0, out_valid}, 64'd0);
        chk("ld_req_valid_wait", {63'd0, mem_req_valid}, 64'd0);
        pulse_resp(64'h1122_3344_5566_7788);
        chk("ld_out_valid_c3", {63'd0, out_valid}, 64'd1);
        chk("ld_out_data", out_data, 64'h1122_3344_5566_7788);
        chk("ld_out_wen", {63'd0, out_wen}, 64'd1);
        chk("ld_out_rd", {59'd0, out_rd}, 64'd7);
        chk("ld_out_misalign", {63'd0, out_misalign}, 64'd0);
        $display("load ld -> out_data=%h", out_data);
        consume();

        // Sub-word loads with lane shift and extension
        do_load("lb",  4'b0000, 64'h8000_0003, 5'd1, 64'h0000_0000_80FF_0000,
                64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 4'b0100, 64'h8000_0003, 5'd2, 64'h0000_0000_80FF_0000,
                64'h8000_0000, 64'h0000_0000_0000_0080);
        do_load("lh",  4'b0001, 64'h8000_0002, 5'd3, 64'h0000_0000_F00D_0000,
                64'h8000_0000, 64'hFFFF_FFFF_FFFF_F00D);
        do_load("lhu", 4'b0101, 64'h8000_0002, 5'd4, 64'h0000_0000_F00D_0000,
                64'h8000_0000, 64'h0000_0000_0000_F00D);
        do_load("lw_hi", 4'b0010, 64'h8000_002C, 5'd5, 64'h7ABC_DEF0_0000_0000,
                64'h8000_0028, 64'h0000_0000_7ABC_DEF0);
        do_load("lwu_hi", 4'b0110, 64'h8000_002C, 5'd6, 64'h8ABC_DEF0_0000_0000,
                64'h8000_0028, 64'h0000_0000_8ABC_DEF0);

        // sh into the top halfword
        accept(4'b1001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 5'd9);
        chk("sh_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("sh_req_addr", mem_req_addr, 64'h8000_0000);
        chk("sh_req_wen", {63'd0, mem_req_wen}, 64'd1);
        chk("sh_req_wmask", {56'd0, mem_req_wmask}, 64'h00C0);
        chk("sh_req_wdata", mem_req_wdata, 64'hABCD_0000_0000_0000);
        @(negedge clk);
        pulse_resp(64'h5555_AAAA_5555_AAAA);
        chk("sh_out_valid", {63'd0, out_valid}, 64'd1);
        chk("sh_out_wen", {63'd0, out_wen}, 64'd0);
        chk("sh_out_data", out_data, 64'd0);
        $display("store sh wmask=%h wdata=%h", mem_req_wmask, mem_req_wdata);
        consume();

        // sb at lane 5
        accept(4'b1000, 64'h8000_0015, 64'h0000_0000_0000_005A, 5'd10);
        chk("sb_req_wmask", {56'd0, mem_req_wmask}, 64'h0020);
        chk("sb_req_wdata", mem_req_wdata, 64'h0000_5A00_0000_0000);
        chk("sb_req_addr", mem_req_addr, 64'h8000_0010);
        @(negedge clk);
        pulse_resp(64'd0);
        $display("store sb wmask=%h wdata=%h", mem_req_wmask, mem_req_wdata);
        consume();

        // Backpressure on request and writeback
        mem_req_ready = 1'b0;
        accept(4'b0010, 64'h8000_0020, 64'd0, 5'd11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_req_addr", mem_req_addr, 64'h8000_0020);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid_req", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_dropped", {63'd0, mem_req_valid}, 64'd0);
        pulse_resp(64'hFFFF_FFFF_8765_4321);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_out_data", out_data, 64'hFFFF_FFFF_8765_4321);
            chk("bp_in_ready_done", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        $display("backpressure lw -> out_data=%h", out_data);
        consume();

        // Misaligned lw
        accept(4'b0010, 64'h8000_0002, 64'd0, 5'd12);
`ifdef YSYX_22050039_LSU_MISALIGN_TRAP_EN
        chk("mis_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mis_out_misalign", {63'd0, out_misalign}, 64'd1);
        chk("mis_out_wen", {63'd0, out_wen}, 64'd0);
        chk("mis_out_data", out_data, 64'd0);
        $display("misaligned lw trapped misalign=%b", out_misalign);
        consume();
`else
        chk("mis_req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("mis_req_addr", mem_req_addr, 64'h8000_0000);
        @(negedge clk);
        pulse_resp(64'h1111_1111_2222_2222);
        chk("mis_out_misalign", {63'd0, out_misalign}, 64'd0);
        chk("mis_out_data", out_data, 64'h0000_0000_2222_2222);
        $display("misaligned lw issued as aligned -> out_data=%h", out_data);
        consume();
`endif

        // Reset while waiting for a response
        accept(4'b0011, 64'h8000_0008, 64'd0, 5'd13);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstw_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rstw_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstw_out_rd", {59'd0, out_rd}, 64'd0);
        rst = 1'b1;
        pulse_resp(64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 4; i++) begin
            chk("rstw_no_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rstw_idle", {63'd0, in_ready}, 64'd1);
            @(negedge clk);
        end
        $display("reset in WAIT -> in_ready=%b out_valid=%b", in_ready, out_valid);

        // Unit still works after the aborted op
        do_load("ld_after_rst", 4'b0011, 64'h8000_0040, 5'd14, 64'hCAFE_F00D_0BAD_BEEF,
                64'h8000_0040, 64'hCAFE_F00D_0BAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
